pipe_flush_ctrl: RTL and testbench

Parametrised pipeline flush/stall controller for the RRV core. It replaces the fixed two-output flush decode with per-register flush and stall vectors for an N-stage pipeline. It adds several behaviours the fixed decode lacks: multi-cycle post-redirect drain, load-use bubble insertion, memory back-pressure freeze, deferral of a redirect that arrives during a freeze, and a stall watchdog. It sits beside the core datapath and drives the enables and clears of every inter-stage pipeline register and the PC.

---
 rtl/pipe_flush_ctrl.sv | 178 +++++++++++++++++
 tb/tb_pipe_flush_ctrl.sv | 157 +++++++++++++++
 2 files changed

// File: rtl/pipe_flush_ctrl.sv
// ---------------------------------------------------------------------------
// pipe_flush_ctrl
//
// Flush/stall controller for an N-stage in-order pipeline. Drives per-register
// flush (clear to bubble) and stall (hold) vectors for the R = NUM_STAGES-1
// inter-stage registers, plus a PC hold. Handles redirect/trap flushes with a
// multi-cycle drain of register 0 (fetch latency), load-use bubble insertion,
// memory back-pressure freeze, redirects deferred across a freeze, and a
// sticky watchdog on long memory stalls.
//
// Ports:
//   clk            core clock, all state on the rising edge
//   rst            synchronous active-high reset
//   redirect_valid 1-cycle pulse: taken branch/jump resolved at REDIRECT_STAGE
//   trap_valid     1-cycle pulse: exception/interrupt, flushes the whole pipe
//   load_use       level: load-use hazard detected in decode
//   mem_busy       level: data memory not ready, freeze the pipe
//   flush[R-1:0]   flush[r]=1 clears register r to a bubble this edge
//   stall[R-1:0]   stall[r]=1 holds register r this edge
//   pc_hold        hold the PC this edge
//   drain_busy     controller is not in RUN
//   stall_timeout  sticky: mem_busy lasted MAX_STALL consecutive cycles
// ---------------------------------------------------------------------------
module pipe_flush_ctrl #(
  parameter int NUM_STAGES       = 5,
  parameter int REDIRECT_STAGE   = 2,
  parameter int LU_STAGE         = 1,
  parameter int REDIRECT_BUBBLES = 2,
  parameter int MAX_STALL        = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  redirect_valid,
  input  logic                  trap_valid,
  input  logic                  load_use,
  input  logic                  mem_busy,
  output logic [NUM_STAGES-2:0] flush,
  output logic [NUM_STAGES-2:0] stall,
  output logic                  pc_hold,
  output logic                  drain_busy,
  output logic                  stall_timeout
);

  localparam int R  = NUM_STAGES - 1;
  localparam int DW = (REDIRECT_BUBBLES == 0) ? 1 : $clog2(REDIRECT_BUBBLES + 1);
  localparam int SW = $clog2(MAX_STALL + 1);

  localparam logic [1:0] S_RUN   = 2'd0;
  localparam logic [1:0] S_DRAIN = 2'd1;
  localparam logic [1:0] S_PEND  = 2'd2;

  localparam logic [R-1:0]  ALL_MASK      = {R{1'b1}};
  localparam logic [R-1:0]  REDIRECT_MASK = R'((1 << REDIRECT_STAGE) - 1);
  localparam logic [R-1:0]  LU_STALL_MASK = R'((1 << LU_STAGE) - 1);
  localparam logic [R-1:0]  LU_FLUSH_MASK = R'(1 << LU_STAGE);
  // While draining, register 0 keeps being flushed, so a freeze holds only
  // the registers behind it.
  localparam logic [R-1:0]  DRAIN_STALL   = ~R'(1);
  localparam logic [DW-1:0] BUBBLES       = DW'(REDIRECT_BUBBLES);
  localparam logic [SW-1:0] MAX_CNT       = SW'(MAX_STALL);
  localparam logic [1:0]    AFTER_FLUSH   = (REDIRECT_BUBBLES > 0) ? S_DRAIN : S_RUN;

  logic [1:0]    state_q, state_n;
  logic [DW-1:0] drain_q, drain_n;
  logic [SW-1:0] stall_cnt_q, stall_cnt_n;
  logic          timeout_q;
  logic [R-1:0]  flush_d, stall_d;
  logic          pc_hold_d;

  // Control decode. Priority: rst > trap > mem_busy > redirect/pending > load_use.
  always_comb begin
    // NOTE: every variable gets a default before the case so no path leaves
    // it unassigned, which would otherwise infer a latch.
    flush_d   = '0;
    stall_d   = '0;
    pc_hold_d = 1'b0;
    state_n   = state_q;
    drain_n   = drain_q;

    case (state_q)
      S_RUN: begin
        if (trap_valid) begin
          flush_d = ALL_MASK;
          state_n = AFTER_FLUSH;
          drain_n = BUBBLES;
        end else if (mem_busy) begin
          stall_d   = ALL_MASK;
          pc_hold_d = 1'b1;
          if (redirect_valid) state_n = S_PEND;
        end else if (redirect_valid) begin
          flush_d = REDIRECT_MASK;
          state_n = AFTER_FLUSH;
          drain_n = BUBBLES;
        end else if (load_use) begin
          stall_d   = LU_STALL_MASK;
          flush_d   = LU_FLUSH_MASK;
          pc_hold_d = 1'b1;
        end
      end

      S_DRAIN: begin
        flush_d[0] = 1'b1;
        if (trap_valid) begin
          flush_d = ALL_MASK;
          drain_n = BUBBLES;
        end else if (mem_busy) begin
          stall_d   = DRAIN_STALL;
          pc_hold_d = 1'b1;
          // A redirect under a freeze is deferred exactly as from RUN; the
          // drain restarts from the full count once it is applied.
          if (redirect_valid) state_n = S_PEND;
        end else if (redirect_valid) begin
          flush_d = flush_d | REDIRECT_MASK;
          drain_n = BUBBLES;
        end else begin
          drain_n = drain_q - DW'(1);
          if (drain_q == DW'(1)) state_n = S_RUN;
        end
      end

      S_PEND: begin
        // A redirect_valid seen here merges with the one already pending.
        if (trap_valid) begin
          flush_d = ALL_MASK;
          state_n = AFTER_FLUSH;
          drain_n = BUBBLES;
        end else if (mem_busy) begin
          stall_d   = ALL_MASK;
          pc_hold_d = 1'b1;
        end else begin
          flush_d = REDIRECT_MASK;
          state_n = AFTER_FLUSH;
          drain_n = BUBBLES;
        end
      end

      default: state_n = S_RUN;
    endcase

    // Flush wins over stall on the same register.
    stall_d = stall_d & ~flush_d;

    if (rst) begin
      flush_d   = ALL_MASK;
      stall_d   = '0;
      pc_hold_d = 1'b0;
    end
  end

  // Watchdog: saturating count of consecutive mem_busy cycles.
  always_comb begin
    stall_cnt_n = '0;
    if (mem_busy) stall_cnt_n = (stall_cnt_q == MAX_CNT) ? stall_cnt_q : stall_cnt_q + SW'(1);
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_RUN;
      drain_q     <= '0;
      stall_cnt_q <= '0;
      timeout_q   <= 1'b0;
    end else begin
      state_q     <= state_n;
      drain_q     <= drain_n;
      stall_cnt_q <= stall_cnt_n;
      timeout_q   <= timeout_q | (stall_cnt_n == MAX_CNT);
    end
  end

  assign flush         = flush_d;
  assign stall         = stall_d;
  assign pc_hold       = pc_hold_d;
  assign drain_busy    = (state_q != S_RUN) & ~rst;
  assign stall_timeout = timeout_q & ~rst;

endmodule

// File: tb/tb_pipe_flush_ctrl.sv
// ---------------------------------------------------------------------------
// tb_pipe_flush_ctrl
//
// Directed bench for pipe_flush_ctrl at default parameters (R=4,
// REDIRECT_STAGE=2, LU_STAGE=1, REDIRECT_BUBBLES=2, MAX_STALL=8). Each step
// drives one cycle of inputs just after a rising edge, then compares the
// combinational outputs mid-cycle against hand-computed values packed as
// {flush, stall, pc_hold, drain_busy, stall_timeout}.
// ---------------------------------------------------------------------------
module tb_pipe_flush_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic       redirect_valid;
  logic       trap_valid;
  logic       load_use;
  logic       mem_busy;
  logic [3:0] flush;
  logic [3:0] stall;
  logic       pc_hold;
  logic       drain_busy;
  logic       stall_timeout;

  int vectors     = 0;
  int miscompares = 0;

  pipe_flush_ctrl dut (
    .clk            (clk),
    .rst            (rst),
    .redirect_valid (redirect_valid),
    .trap_valid     (trap_valid),
    .load_use       (load_use),
    .mem_busy       (mem_busy),
    .flush          (flush),
    .stall          (stall),
    .pc_hold        (pc_hold),
    .drain_busy     (drain_busy),
    .stall_timeout  (stall_timeout)
  );

  always #5 clk = ~clk;

  // One cycle: drive inputs, check outputs mid-cycle, advance past the edge.
  task automatic cyc(input string tag,
                     input logic r, input logic tv, input logic rv,
                     input logic lu, input logic mb,
                     input logic [3:0] ef, input logic [3:0] es,
                     input logic eph, input logic edb, input logic eto);
    logic [10:0] obs;
    logic [10:0] exp;
    rst            = r;
    trap_valid     = tv;
    redirect_valid = rv;
    load_use       = lu;
    mem_busy       = mb;
    #2;
    obs = {flush, stall, pc_hold, drain_busy, stall_timeout};
    exp = {ef, es, eph, edb, eto};
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed flush=%b stall=%b pc_hold=%b drain_busy=%b timeout=%b, expected flush=%b stall=%b pc_hold=%b drain_busy=%b timeout=%b",
             tag, obs[10:7], obs[6:3], obs[2], obs[1], obs[0],
             exp[10:7], exp[6:3], exp[2], exp[1], exp[0]);
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1; trap_valid = 1'b0; redirect_valid = 1'b0;
    load_use = 1'b0; mem_busy = 1'b0;
    #1;

    // Reset held two cycles, then idle.
    //   tag         rst tv rv lu mb  flush    stall    ph  db  to
    cyc("rst_0",     1, 0, 0, 0, 0, 4'b1111, 4'b0000, 0, 0, 0);
    cyc("rst_1",     1, 0, 0, 0, 0, 4'b1111, 4'b0000, 0, 0, 0);
    cyc("idle",      0, 0, 0, 0, 0, 4'b0000, 4'b0000, 0, 0, 0);

    // Redirect in RUN: 0011, then two drain cycles of 0001.
    cyc("rd_c0",     0, 0, 1, 0, 0, 4'b0011, 4'b0000, 0, 0, 0);
    cyc("rd_c1",     0, 0, 0, 0, 0, 4'b0001, 4'b0000, 0, 1, 0);
    cyc("rd_c2",     0, 0, 0, 0, 0, 4'b0001, 4'b0000, 0, 1, 0);
    cyc("rd_c3",     0, 0, 0, 0, 0, 4'b0000, 4'b0000, 0, 0, 0);

    // Load-use bubble for one cycle.
    cyc("lu_c0",     0, 0, 0, 1, 0, 4'b0010, 4'b0001, 1, 0, 0);
    cyc("lu_c1",     0, 0, 0, 0, 0, 4'b0000, 4'b0000, 0, 0, 0);

    // Redirect overrides load-use; load-use ignored while draining.
    cyc("rdlu_c0",   0, 0, 1, 1, 0, 4'b0011, 4'b0000, 0, 0, 0);
    cyc("rdlu_c1",   0, 0, 0, 1, 0, 4'b0001, 4'b0000, 0, 1, 0);
    cyc("rdlu_c2",   0, 0, 0, 0, 0, 4'b0001, 4'b0000, 0, 1, 0);
    cyc("rdlu_c3",   0, 0, 0, 0, 0, 4'b0000, 4'b0000, 0, 0, 0);

    // mem_busy outranks load-use.
    cyc("lumb",      0, 0, 0, 1, 1, 4'b0000, 4'b1111, 1, 0, 0);
    cyc("lumb_end",  0, 0, 0, 0, 0, 4'b0000, 4'b0000, 0, 0, 0);

    // Redirect coincident with a 3-cycle freeze: deferred via PEND.
    cyc("pend_c0",   0, 0, 1, 0, 1, 4'b0000, 4'b1111, 1, 0, 0);
    cyc("pend_c1",   0, 0, 0, 0, 1, 4'b0000, 4'b1111, 1, 1, 0);
    cyc("pend_c2",   0, 0, 1, 0, 1, 4'b0000, 4'b1111, 1, 1, 0);
    cyc("pend_c3",   0, 0, 0, 0, 0, 4'b0011, 4'b0000, 0, 1, 0);
    cyc("pend_c4",   0, 0, 0, 0, 0, 4'b0001, 4'b0000, 0, 1, 0);
    cyc("pend_c5",   0, 0, 0, 0, 0, 4'b0001, 4'b0000, 0, 1, 0);
    cyc("pend_c6",   0, 0, 0, 0, 0, 4'b0000, 4'b0000, 0, 0, 0);

    // Freeze during DRAIN: register 0 still flushed, count frozen.
    cyc("dmb_c0",    0, 0, 1, 0, 0, 4'b0011, 4'b0000, 0, 0, 0);
    cyc("dmb_c1",    0, 0, 0, 0, 1, 4'b0001, 4'b1110, 1, 1, 0);
    cyc("dmb_c2",    0, 0, 0, 0, 0, 4'b0001, 4'b0000, 0, 1, 0);
    cyc("dmb_c3",    0, 0, 0, 0, 0, 4'b0001, 4'b0000, 0, 1, 0);
    cyc("dmb_c4",    0, 0, 0, 0, 0, 4'b0000, 4'b0000, 0, 0, 0);

    // Trap in DRAIN at drain_cnt=1 reloads the count.
    cyc("tdr_c0",    0, 0, 1, 0, 0, 4'b0011, 4'b0000, 0, 0, 0);
    cyc("tdr_c1",    0, 0, 0, 0, 0, 4'b0001, 4'b0000, 0, 1, 0);
    cyc("tdr_trap",  0, 1, 0, 0, 0, 4'b1111, 4'b0000, 0, 1, 0);
    cyc("tdr_c3",    0, 0, 0, 0, 0, 4'b0001, 4'b0000, 0, 1, 0);
    cyc("tdr_c4",    0, 0, 0, 0, 0, 4'b0001, 4'b0000, 0, 1, 0);
    cyc("tdr_c5",    0, 0, 0, 0, 0, 4'b0000, 4'b0000, 0, 0, 0);

    // Trap in PEND drops the pending redirect: no 0011 afterwards.
    cyc("tpd_c0",    0, 0, 1, 0, 1, 4'b0000, 4'b1111, 1, 0, 0);
    cyc("tpd_trap",  0, 1, 0, 0, 1, 4'b1111, 4'b0000, 0, 1, 0);
    cyc("tpd_c2",    0, 0, 0, 0, 0, 4'b0001, 4'b0000, 0, 1, 0);
    cyc("tpd_c3",    0, 0, 0, 0, 0, 4'b0001, 4'b0000, 0, 1, 0);
    cyc("tpd_c4",    0, 0, 0, 0, 0, 4'b0000, 4'b0000, 0, 0, 0);

    // Reset mid-PEND discards the pending redirect.
    cyc("rpd_c0",    0, 0, 1, 0, 1, 4'b0000, 4'b1111, 1, 0, 0);
    cyc("rpd_rst",   1, 0, 0, 0, 1, 4'b1111, 4'b0000, 0, 0, 0);
    cyc("rpd_c2",    0, 0, 0, 0, 0, 4'b0000, 4'b0000, 0, 0, 0);

    // Two 7-cycle bursts separated by one idle cycle never fire the watchdog.
    for (int i = 0; i < 7; i++)
      cyc("wd7a",    0, 0, 0, 0, 1, 4'b0000, 4'b1111, 1, 0, 0);
    cyc("wd7_gap",   0, 0, 0, 0, 0, 4'b0000, 4'b0000, 0, 0, 0);
    for (int i = 0; i < 7; i++)
      cyc("wd7b",    0, 0, 0, 0, 1, 4'b0000, 4'b1111, 1, 0, 0);
    cyc("wd7_end",   0, 0, 0, 0, 0, 4'b0000, 4'b0000, 0, 0, 0);

    // An 8-cycle burst fires it after the 8th cycle; sticky until reset.
    for (int i = 0; i < 8; i++)
      cyc("wd8",     0, 0, 0, 0, 1, 4'b0000, 4'b1111, 1, 0, 0);
    cyc("wd8_set",   0, 0, 0, 0, 0, 4'b0000, 4'b0000, 0, 0, 1);
    cyc("wd8_hold",  0, 0, 0, 0, 0, 4'b0000, 4'b0000, 0, 0, 1);
    cyc("wd8_rst",   1, 0, 0, 0, 0, 4'b1111, 4'b0000, 0, 0, 0);
    cyc("wd8_clr",   0, 0, 0, 0, 0, 4'b0000, 4'b0000, 0, 0, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
